// File: rtl/serial_pkg.sv
// Shared definitions for the serial framing blocks (receiver and transmitter):
// state encoding, default header byte, default payload length, RAM address width.
package serial_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;
  localparam int         DATA_LENGTH_DEFAULT = 22;
  localparam int         ADDR_W              = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_COMMAND,
    ST_GET_DATA,
    ST_GET_CHECKSUM,
    ST_WAIT_DONE
  } rx_state_t;

endpackage

// File: rtl/serial_rx_timeout.sv
// Inter-byte watchdog: down-counter reloaded by clear_i; expire_o flags the
// cycle in which TIMEOUT_CYCLES-1 cycles have elapsed since the last clear.
module serial_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int                 CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Counter steps from 1 to 0 on this edge; a same-cycle clear takes priority.
  assign expire_o = !clear_i && (r_count == CNT_W'(1));

endmodule

// File: rtl/serial_receiver_state_machine.sv
// Framed-packet receiver: header, command, DATA_LENGTH payload bytes into RAM.
// Optional checksum byte (running XOR) when RX_CHECKSUM_EN is defined.
module serial_receiver_state_machine
  import serial_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE    = HEADER_BYTE_DEFAULT,
  parameter int         DATA_LENGTH    = DATA_LENGTH_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              new_rx_data_i,
  input  logic [7:0]        rx_byte_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_data_o,
  output logic [7:0]        command_o,
  output logic              frame_done_o,
  output logic              frame_error_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_LENGTH - 1);

  rx_state_t         r_state;
  rx_state_t         w_next_state;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_data;
  logic [7:0]        r_command;
  logic              r_frame_done;
  logic              r_frame_error;

  logic w_timer_clear;
  logic w_timer_expire;
  logic w_capture_cmd;
  logic w_write_byte;
  logic w_set_done;
  logic w_set_error;

`ifdef RX_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       w_header;
  assign w_header = (r_state == ST_IDLE) && new_rx_data_i && (rx_byte_i == HEADER_BYTE);
`endif

  assign w_timer_clear = new_rx_data_i || (r_state == ST_IDLE);

  serial_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_timer_clear),
    .expire_o(w_timer_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path infers a latch.
    w_next_state  = r_state;
    w_capture_cmd = 1'b0;
    w_write_byte  = 1'b0;
    w_set_done    = 1'b0;
    w_set_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (new_rx_data_i && (rx_byte_i == HEADER_BYTE)) begin
          w_next_state = ST_GET_COMMAND;
        end
      end
      ST_GET_COMMAND: begin
        if (new_rx_data_i) begin
          w_capture_cmd = 1'b1;
          w_next_state  = ST_GET_DATA;
        end else if (w_timer_expire) begin
          w_set_error  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (new_rx_data_i) begin
          w_write_byte = 1'b1;
          if (r_addr_cnt == LAST_ADDR) begin
`ifdef RX_CHECKSUM_EN
            w_next_state = ST_GET_CHECKSUM;
`else
            w_next_state = ST_WAIT_DONE;
`endif
          end
        end else if (w_timer_expire) begin
          w_set_error  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
`ifdef RX_CHECKSUM_EN
      ST_GET_CHECKSUM: begin
        if (new_rx_data_i) begin
          if (rx_byte_i == r_xor) begin
            w_next_state = ST_WAIT_DONE;
          end else begin
            w_set_error  = 1'b1;
            w_next_state = ST_IDLE;
          end
        end else if (w_timer_expire) begin
          w_set_error  = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
`endif
      // Strobes landing here are dropped; the frame is already complete.
      ST_WAIT_DONE: begin
        w_set_done   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr_cnt    <= '0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data    <= '0;
      r_command     <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_ram_we      <= w_write_byte;
      r_frame_done  <= w_set_done;
      r_frame_error <= w_set_error;
      if (w_capture_cmd) begin
        r_command  <= rx_byte_i;
        r_addr_cnt <= '0;
      end
      if (w_write_byte) begin
        r_ram_data <= rx_byte_i;
        r_ram_addr <= r_addr_cnt;
        // Saturate at the last address so the counter never wraps.
        if (r_addr_cnt != LAST_ADDR) begin
          r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        end
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_xor <= '0;
    end else if (w_header) begin
      r_xor <= '0;
    end else if (w_capture_cmd || w_write_byte) begin
      r_xor <= r_xor ^ rx_byte_i;
    end
  end
`endif

  assign ram_we_o      = r_ram_we;
  assign ram_addr_o    = r_ram_addr;
  assign ram_data_o    = r_ram_data;
  assign command_o     = r_command;
  assign frame_done_o  = r_frame_done;
  assign frame_error_o = r_frame_error;
  assign busy_o        = (r_state != ST_IDLE);

endmodule
